// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and load scoreboard.
// Merges ALU and LSU write-back requests onto the register file, PC and CPSR
// write ports through a one-cycle registered output stage. It tracks
// destinations of outstanding loads and flags read-after-write hazards to issue.
module regfile_wb_arbiter #(
   parameter int unsigned WORD_SIZE  = 32,
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   // ALU write-back request
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [WORD_SIZE-1:0]  alu_data,
   input  logic                  alu_cpsr_we,
   input  logic [WORD_SIZE-1:0]  alu_cpsr,
   // LSU load write-back request
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [WORD_SIZE-1:0]  lsu_data,
   // Issue stage: load issue and hazard check
   input  logic                  issue_load,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic [ADDR_WIDTH-1:0] chk_rn,
   input  logic [ADDR_WIDTH-1:0] chk_rm,
   input  logic [ADDR_WIDTH-1:0] chk_rs,
   input  logic                  chk_rn_en,
   input  logic                  chk_rm_en,
   input  logic                  chk_rs_en,
   output logic                  hazard,
   // Register file write ports
   output logic                  rd_we,
   output logic [ADDR_WIDTH-1:0] write_rd,
   output logic [WORD_SIZE-1:0]  rd_in,
   output logic                  pc_we,
   output logic [WORD_SIZE-1:0]  pc_in,
   output logic                  cpsr_we,
   output logic [WORD_SIZE-1:0]  cpsr_in
);

   localparam logic [ADDR_WIDTH-1:0] PcIdx = ADDR_WIDTH'(NUM_REGS - 1);

   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic                  prio_q, prio_d;     // 0: ALU wins a tie, 1: LSU wins a tie
   logic                  rd_we_q, rd_we_d;
   logic [ADDR_WIDTH-1:0] write_rd_q, write_rd_d;
   logic [WORD_SIZE-1:0]  rd_in_q, rd_in_d;
   logic                  pc_we_q, pc_we_d;
   logic [WORD_SIZE-1:0]  pc_in_q, pc_in_d;
   logic                  cpsr_we_q, cpsr_we_d;
   logic [WORD_SIZE-1:0]  cpsr_in_q, cpsr_in_d;

   logic                  alu_elig, lsu_elig;
   logic                  grant_alu, grant_lsu;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [WORD_SIZE-1:0]  sel_data;

   // Source is unsafe to read while its load is pending or its write has not yet committed.
   function automatic logic src_hit(input logic [ADDR_WIDTH-1:0] r);
      return busy_q[r] || (rd_we_q && (write_rd_q == r)) || (pc_we_q && (r == PcIdx));
   endfunction

   // Eligibility, round-robin grant on contention, and priority update.
   always_comb begin
      // An ALU write to a register with a pending load waits so the load cannot overwrite it.
      alu_elig  = alu_valid && !busy_q[alu_rd];
      lsu_elig  = lsu_valid;
      grant_alu = !reset && alu_elig && (!lsu_elig || !prio_q);
      grant_lsu = !reset && lsu_elig && (!alu_elig || prio_q);
      prio_d    = (alu_elig && lsu_elig) ? ~prio_q : prio_q;
   end

   assign alu_ready = grant_alu;
   assign lsu_ready = grant_lsu;

   // Next state of the output stage and the load scoreboard.
   always_comb begin
      sel_rd     = grant_alu ? alu_rd : lsu_rd;
      sel_data   = grant_alu ? alu_data : lsu_data;
      rd_we_d    = 1'b0;
      pc_we_d    = 1'b0;
      cpsr_we_d  = 1'b0;
      write_rd_d = write_rd_q;
      rd_in_d    = rd_in_q;
      pc_in_d    = pc_in_q;
      cpsr_in_d  = cpsr_in_q;
      if (grant_alu || grant_lsu) begin
         if (sel_rd == PcIdx) begin
            pc_we_d = 1'b1;
            pc_in_d = sel_data;
         end else begin
            rd_we_d    = 1'b1;
            write_rd_d = sel_rd;
            rd_in_d    = sel_data;
         end
      end
      if (grant_alu && alu_cpsr_we) begin
         cpsr_we_d = 1'b1;
         cpsr_in_d = alu_cpsr;
      end
      busy_d = busy_q;
      if (grant_lsu) busy_d[lsu_rd] = 1'b0;
      // Set is applied last so a new load to the same register wins over the clear.
      if (issue_load) busy_d[issue_rd] = 1'b1;
   end

   // Hazard: any enabled source register is pending or in its commit window.
   always_comb begin
      hazard = (chk_rn_en && src_hit(chk_rn)) ||
               (chk_rm_en && src_hit(chk_rm)) ||
               (chk_rs_en && src_hit(chk_rs));
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q     <= '0;
         prio_q     <= 1'b0;
         rd_we_q    <= 1'b0;
         write_rd_q <= '0;
         rd_in_q    <= '0;
         pc_we_q    <= 1'b0;
         pc_in_q    <= '0;
         cpsr_we_q  <= 1'b0;
         cpsr_in_q  <= '0;
      end else begin
         busy_q     <= busy_d;
         prio_q     <= prio_d;
         rd_we_q    <= rd_we_d;
         write_rd_q <= write_rd_d;
         rd_in_q    <= rd_in_d;
         pc_we_q    <= pc_we_d;
         pc_in_q    <= pc_in_d;
         cpsr_we_q  <= cpsr_we_d;
         cpsr_in_q  <= cpsr_in_d;
      end
   end

   assign rd_we    = rd_we_q;
   assign write_rd = write_rd_q;
   assign rd_in    = rd_in_q;
   assign pc_we    = pc_we_q;
   assign pc_in    = pc_in_q;
   assign cpsr_we  = cpsr_we_q;
   assign cpsr_in  = cpsr_in_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter and load scoreboard for the CPU register file. It merges register write requests from the ALU and the load/store unit (LSU) onto the register file's single write port, its PC write port and its CPSR write port. It tracks registers with outstanding loads and flags read-after-write hazards to the issue stage. It sits between the execute/memory stages and the register file.

Parameters:
WORD_SIZE, 32, data width of registers, PC and CPSR
NUM_REGS, 16, number of architectural registers; index 15 is the PC
ADDR_WIDTH, 4, register address width, log2(NUM_REGS)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU has a result to write back
alu_ready  output  1  ALU result accepted this cycle (transfer = alu_valid && alu_ready)
alu_rd  input  ADDR_WIDTH  ALU destination register
alu_data  input  WORD_SIZE  ALU result
alu_cpsr_we  input  1  ALU result also updates CPSR
alu_cpsr  input  WORD_SIZE  new CPSR value
lsu_valid  input  1  LSU has load data to write back
lsu_ready  output  1  LSU data accepted this cycle
lsu_rd  input  ADDR_WIDTH  load destination register
lsu_data  input  WORD_SIZE  load data
issue_load  input  1  a load is issued this cycle; marks issue_rd busy
issue_rd  input  ADDR_WIDTH  destination of the issued load
chk_rn, chk_rm, chk_rs  input  ADDR_WIDTH each  source registers of the instruction in issue
chk_rn_en, chk_rm_en, chk_rs_en  input  1 each  corresponding source is used
hazard  output  1  issue must stall (combinational)
rd_we  output  1  register file write enable
write_rd  output  ADDR_WIDTH  register file write address
rd_in  output  WORD_SIZE  register file write data
pc_we  output  1  PC write enable
pc_in  output  WORD_SIZE  PC write data
cpsr_we  output  1  CPSR write enable
cpsr_in  output  WORD_SIZE  CPSR write data

Behaviour:
- Reset: all outputs 0, busy[] all 0, priority pointer = ALU. Reset mid-operation discards the output stage and all busy bits. Requests are not held across reset.
- State: busy[NUM_REGS], prio (0 = ALU first, 1 = LSU first), and a registered output stage.
- Eligibility: LSU is eligible when lsu_valid. ALU is eligible when alu_valid && !busy[alu_rd]. A WAW against a pending load stalls the ALU.
- Grant: one transfer per cycle, at most.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the prio side is granted and prio flips to the other side.
  - Uncontended grants leave prio unchanged.
- alu_ready / lsu_ready: combinational, asserted only for the granted requester. They are 0 when that requester's valid is 0.
- Latency: a transfer in cycle N drives the write outputs for exactly cycle N+1 (registered). The register file commits at the end of N+1.
- Output stage, for an accepted request with destination rd and data d:
  - rd != 15: rd_we=1, write_rd=rd, rd_in=d, pc_we=0.
  - rd == 15: pc_we=1, pc_in=d, rd_we=0. write_rd and rd_in hold their previous values.
  - ALU grant with alu_cpsr_we: cpsr_we=1, cpsr_in=alu_cpsr, in the same cycle as the register write.
  - LSU grants never write CPSR.
  - No transfer: all enables 0 next cycle; data outputs hold.
- Scoreboard:
  - issue_load sets busy[issue_rd].
  - An LSU transfer clears busy[lsu_rd].
  - Set and clear of the same register in the same cycle: set wins.
- hazard = OR over enabled chk_x of (busy[chk_x] || (rd_we && write_rd==chk_x) || (pc_we && chk_x==15)).
  - Covers the one-cycle window before the register file commits.
- No bypass: data reaches readers only through the register file.

Test Plan:
- Reset asserted mid-transfer with busy[3]=1 -> next cycle all enables 0, busy cleared, hazard=0 for chk_rn=3.
- ALU only: alu_valid, alu_rd=2, alu_data=0x1234, alu_cpsr_we=1, alu_cpsr=0x80000000 -> alu_ready same cycle; next cycle rd_we=1, write_rd=2, rd_in=0x1234, cpsr_we=1, cpsr_in=0x80000000.
- ALU and LSU both valid for 3 cycles (rd 1 / rd 4) -> grants in order ALU, LSU, ALU; exactly one enable per cycle.
- issue_load rd=5, then chk_rm=5 with chk_rm_en=1 -> hazard=1 until the LSU write to r5 commits. hazard=1 also during the output-stage cycle and =0 the cycle after.
- ALU write to r5 while busy[5]=1 -> alu_ready=0 until the LSU transfer for r5 is accepted.
- LSU write rd=15, data=0x100 -> next cycle pc_we=1, pc_in=0x100, rd_we=0. Same cycle issue_load and LSU clear of r7 -> busy[7] stays 1.
